// File: rtl/rx_clk_div_if.sv
// rx_clk_div_if
// Groups the divider's control inputs and clock/tick outputs into one bundle.
//   i_clk_en     divider enable
//   i_div_ratio  requested division ratio N (unsigned)
//   o_div_clk    divided clock, or the reference clock in bypass
//   o_tick       one reference-cycle pulse at the start of each divided period
// The master modport drives the controls, the slave modport is the divider.
interface rx_clk_div_if #(
  parameter int data_width = 8
);
  logic                  i_clk_en;
  logic [data_width-1:0] i_div_ratio;
  logic                  o_div_clk;
  logic                  o_tick;

  modport master (
    output i_clk_en,
    output i_div_ratio,
    input  o_div_clk,
    input  o_tick
  );

  modport slave (
    input  i_clk_en,
    input  i_div_ratio,
    output o_div_clk,
    output o_tick
  );
endinterface

// File: rtl/rx_clk_div.sv
// rx_clk_div
// Integer clock divider for the UART receiver (also usable on the TX side).
// Divides i_ref_clk by a ratio N in 2..255 with a registered waveform whose
// high phase is floor(N/2) cycles and low phase ceil(N/2) cycles. Ratio 0/1
// or a low enable bypasses the divider and passes i_ref_clk straight through.
// Ports:
//   i_ref_clk  reference clock, all flops on its rising edge
//   i_rst_n    asynchronous active-low reset
//   bus        rx_clk_div_if.slave: i_clk_en, i_div_ratio in; o_div_clk, o_tick out
module rx_clk_div #(
  parameter int data_width = 8
) (
  input  logic         i_ref_clk,
  input  logic         i_rst_n,
  rx_clk_div_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [data_width-1:0] ratio_q, ratio_d;
  logic [data_width-1:0] cnt_q,   cnt_d;
  logic                  div_q,   div_d;
  logic                  tick_q,  tick_d;

  logic                  ratioValid;
  logic                  atWrap;

  // Ratios below 2 cannot be divided and select bypass instead.
  assign ratioValid = (bus.i_div_ratio >= data_width'(2));
  assign atWrap     = (cnt_q == (ratio_q - data_width'(1)));

  // Next-state logic. The ratio input is only looked at on entry and at the
  // period boundary, so a mid-period change never cuts a period short.
  // The output flops are computed from the next counter/ratio so that the
  // waveform comes straight out of registers with no decode on the output.
  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    cnt_d   = '0;
    div_d   = 1'b0;
    tick_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_clk_en && ratioValid) begin
          state_d = RUN;
          ratio_d = bus.i_div_ratio;
        end
      end
      RUN: begin
        if (!bus.i_clk_en) begin
          state_d = IDLE;
        end else if (atWrap) begin
          if (ratioValid) begin
            ratio_d = bus.i_div_ratio;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + data_width'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == RUN) begin
      div_d  = (cnt_d < (ratio_d >> 1));
      tick_d = (cnt_d == '0);
    end
  end

  // All divider state, cleared asynchronously so the output drops back to
  // bypass the moment reset asserts.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ratio_q <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

  // Bypass mux: the reference clock passes through whenever not running.
  // Switching in or out of bypass may produce one short phase.
  assign bus.o_div_clk = (state_q == RUN) ? div_q : i_ref_clk;
  assign bus.o_tick    = tick_q;

endmodule
